voice_mix_sequencer: RTL and testbench

Sample-rate front end that produces the filter's input stream. It owns the sample-rate tick and scans the voice samples through a time-multiplexed select port. It builds two mixes: the filter-routed mix (filt_out, pulsed with sample_valid into the SVF audio_in/sample_valid pair) and the bypass mix (byp_out). Both are volume-scaled and saturated to 8-bit signed.

---
 rtl/voice_mix_pkg.sv | 29 ++
 rtl/mix_scale_sat.sv | 38 +++
 rtl/voice_mix_sequencer.sv | 130 +++++++++++++
 tb/tb_voice_mix_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_mix_pkg.sv
// Shared types and helpers for the voice mix sequencer.
// Build option VOICE_MIX_SAT_EN selects saturating output scaling.
package voice_mix_pkg;

    localparam int SAMPLE_W = 8;
    localparam int VOL_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SCALE,
        OUT
    } mix_state_t;

    function automatic logic [SAMPLE_W-1:0] sat_to_8(
        input logic signed [31:0] v
    );
        logic [SAMPLE_W-1:0] r;
        if (v > 32'sd127) begin
            r = 8'h7f;
        end else if (v < -32'sd128) begin
            r = 8'h80;
        end else begin
            r = v[SAMPLE_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/mix_scale_sat.sv
// Volume scaling of one mix path: (acc * volume) >>> 4, then
// saturate (VOICE_MIX_SAT_EN) or wrap to 8 bits.
module mix_scale_sat
    import voice_mix_pkg::*;
#(
    parameter int ACC_W = 11
) (
    input  logic signed [ACC_W-1:0]    acc,
    input  logic        [VOL_W-1:0]    volume,
    output logic        [SAMPLE_W-1:0] result
);

    localparam int PROD_W = ACC_W + VOL_W + 1;

    logic signed [PROD_W-1:0] acc_x;
    logic signed [PROD_W-1:0] vol_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;

    assign acc_x   = acc;
    assign vol_x   = {{(PROD_W-VOL_W){1'b0}}, volume};
    assign prod    = acc_x * vol_x;
    // Arithmetic shift floors toward minus infinity.
    assign shifted = prod >>> VOL_W;

`ifdef VOICE_MIX_SAT_EN
    logic signed [31:0] wide;

    assign wide   = 32'(shifted);
    assign result = sat_to_8(wide);
`else
    logic unused_hi;

    assign result    = shifted[SAMPLE_W-1:0];
    assign unused_hi = ^shifted[PROD_W-1:SAMPLE_W];
`endif

endmodule

// File: rtl/voice_mix_sequencer.sv
// Sample-rate front end: scans voices, builds filter and bypass mixes.
// Define VOICE_MIX_SAT_EN for saturating (instead of wrapping) output.
module voice_mix_sequencer
    import voice_mix_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int SAMPLE_DIV = 16,
    parameter int VSEL_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic [VSEL_W-1:0]     voice_sel,
    input  logic [SAMPLE_W-1:0]   voice_sample,
    input  logic [NUM_VOICES-1:0] filt_mask,
    input  logic [VOL_W-1:0]      volume,
    output logic [SAMPLE_W-1:0]   filt_out,
    output logic [SAMPLE_W-1:0]   byp_out,
    output logic                  sample_valid,
    output logic                  busy,
    output logic                  overrun
);

    localparam int ACC_W = SAMPLE_W + VSEL_W + 1;
    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [VSEL_W-1:0] VSEL_LAST = VSEL_W'(NUM_VOICES - 1);

    mix_state_t               state;
    logic [CNT_W-1:0]         cnt;
    logic                     tick;
    logic [NUM_VOICES-1:0]    mask_q;
    logic [VOL_W-1:0]         vol_q;
    logic signed [ACC_W-1:0]  filt_acc;
    logic signed [ACC_W-1:0]  byp_acc;
    logic signed [ACC_W-1:0]  sample_x;
    logic [SAMPLE_W-1:0]      filt_scaled;
    logic [SAMPLE_W-1:0]      byp_scaled;

    assign tick = enable && (cnt == CNT_LAST);

    assign sample_x = {{(ACC_W-SAMPLE_W){voice_sample[SAMPLE_W-1]}},
                       voice_sample};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            voice_sel    <= '0;
            mask_q       <= '0;
            vol_q        <= '0;
            filt_acc     <= '0;
            byp_acc      <= '0;
            filt_out     <= '0;
            byp_out      <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            // A tick mid-frame is dropped; the frame runs to completion.
            if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (tick) begin
                        state     <= ACCUM;
                        mask_q    <= filt_mask;
                        vol_q     <= volume;
                        filt_acc  <= '0;
                        byp_acc   <= '0;
                        voice_sel <= '0;
                        busy      <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (mask_q[voice_sel]) begin
                        filt_acc <= filt_acc + sample_x;
                    end else begin
                        byp_acc <= byp_acc + sample_x;
                    end
                    if (voice_sel == VSEL_LAST) begin
                        voice_sel <= '0;
                        state     <= SCALE;
                    end else begin
                        voice_sel <= voice_sel + VSEL_W'(1);
                    end
                end
                SCALE: begin
                    filt_out <= filt_scaled;
                    byp_out  <= byp_scaled;
                    state    <= OUT;
                end
                OUT: begin
                    sample_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    mix_scale_sat #(
        .ACC_W(ACC_W)
    ) u_filt_scale (
        .acc    (filt_acc),
        .volume (vol_q),
        .result (filt_scaled)
    );

    mix_scale_sat #(
        .ACC_W(ACC_W)
    ) u_byp_scale (
        .acc    (byp_acc),
        .volume (vol_q),
        .result (byp_scaled)
    );

endmodule

// File: tb/tb_voice_mix_sequencer.sv
// Directed bench for voice_mix_sequencer (default and fast-divider
// instances); expectations follow VOICE_MIX_SAT_EN.
module tb_voice_mix_sequencer;

`ifdef VOICE_MIX_SAT_EN
    localparam int EXP_POS = 127;
    localparam int EXP_NEG = -128;
`else
    localparam int EXP_POS = 101;
    localparam int EXP_NEG = -104;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] voice_sel;
    logic [7:0] voice_sample;
    logic [2:0] filt_mask = 3'b000;
    logic [3:0] volume = 4'd0;
    logic [7:0] filt_out;
    logic [7:0] byp_out;
    logic       sample_valid;
    logic       busy;
    logic       overrun;

    logic       rst_b = 1'b1;
    logic       enable_b = 1'b0;
    logic [1:0] voice_sel_b;
    logic [7:0] voice_sample_b;
    logic [2:0] filt_mask_b = 3'b000;
    logic [3:0] volume_b = 4'd0;
    logic [7:0] filt_out_b;
    logic [7:0] byp_out_b;
    logic       sample_valid_b;
    logic       busy_b;
    logic       overrun_b;

    logic [7:0] voices [3];

    int errors = 0;
    int checks = 0;
    int n;
    int pulses;

    always #5 clk = ~clk;

    assign voice_sample   = (voice_sel < 2'd3) ? voices[voice_sel] : 8'h00;
    assign voice_sample_b = (voice_sel_b < 2'd3) ? voices[voice_sel_b] : 8'h00;

    voice_mix_sequencer #(
        .NUM_VOICES(3),
        .SAMPLE_DIV(16)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .voice_sel    (voice_sel),
        .voice_sample (voice_sample),
        .filt_mask    (filt_mask),
        .volume       (volume),
        .filt_out     (filt_out),
        .byp_out      (byp_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    voice_mix_sequencer #(
        .NUM_VOICES(3),
        .SAMPLE_DIV(4)
    ) u_ovr (
        .clk          (clk),
        .rst          (rst_b),
        .enable       (enable_b),
        .voice_sel    (voice_sel_b),
        .voice_sample (voice_sample_b),
        .filt_mask    (filt_mask_b),
        .volume       (volume_b),
        .filt_out     (filt_out_b),
        .byp_out      (byp_out_b),
        .sample_valid (sample_valid_b),
        .busy         (busy_b),
        .overrun      (overrun_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_voices(input int a, input int b, input int c);
        voices[0] = 8'(a);
        voices[1] = 8'(b);
        voices[2] = 8'(c);
    endtask

    // Edges until sample_valid is seen; -1 if the budget expires.
    task automatic wait_valid(input int max, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!sample_valid && cnt < max);
        if (!sample_valid) cnt = -1;
    endtask

    task automatic wait_busy(input int max, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!busy && cnt < max);
        if (!busy) cnt = -1;
    endtask

    initial begin
        set_voices(0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_filt", int'($signed(filt_out)), 0);
        check("rst_byp", int'($signed(byp_out)), 0);
        check("rst_valid", int'(sample_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ovr", int'(overrun), 0);
        check("rst_vsel", int'(voice_sel), 0);

        // Basic mix, first pulse 16+5 edges after release
        set_voices(100, 50, -20);
        filt_mask = 3'b001;
        volume    = 4'd15;
        enable    = 1'b1;
        rst       = 1'b0;
        wait_valid(40, n);
        check("first_lat", n, 21);
        check("mix_filt", int'($signed(filt_out)), 93);
        check("mix_byp", int'($signed(byp_out)), 28);
        wait_valid(40, n);
        check("period", n, 16);
        wait_busy(40, n);
        wait_valid(10, n);
        check("tick_lat", n, 5);
        check("no_ovr", int'(overrun), 0);

        // Overflowing sums: saturate or wrap
        @(negedge clk);
        set_voices(127, 127, 127);
        filt_mask = 3'b111;
        wait_valid(40, n);
        check("pos_valid", n > 0 ? 1 : 0, 1);
        check("pos_filt", int'($signed(filt_out)), EXP_POS);
        check("pos_byp", int'($signed(byp_out)), 0);
        @(negedge clk);
        set_voices(-128, -128, -128);
        wait_valid(40, n);
        check("neg_filt", int'($signed(filt_out)), EXP_NEG);
        check("neg_byp", int'($signed(byp_out)), 0);

        // Zero volume still pulses
        @(negedge clk);
        set_voices(100, 50, -20);
        filt_mask = 3'b001;
        volume    = 4'd0;
        wait_valid(40, n);
        check("vol0_valid", n > 0 ? 1 : 0, 1);
        check("vol0_filt", int'($signed(filt_out)), 0);
        check("vol0_byp", int'($signed(byp_out)), 0);

        // Mid-frame mask/volume change applies to next frame only
        @(negedge clk);
        volume = 4'd15;
        wait_busy(40, n);
        @(negedge clk);
        filt_mask = 3'b110;
        volume    = 4'd8;
        wait_valid(10, n);
        check("old_filt", int'($signed(filt_out)), 93);
        check("old_byp", int'($signed(byp_out)), 28);
        wait_valid(40, n);
        check("new_filt", int'($signed(filt_out)), 15);
        check("new_byp", int'($signed(byp_out)), 50);

        // Reset during ACCUM
        wait_busy(40, n);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_filt", int'($signed(filt_out)), 0);
        check("mrst_byp", int'($signed(byp_out)), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_valid", int'(sample_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_valid(40, n);
        check("mrst_lat", n, 21);
        check("mrst_next", int'($signed(byp_out)), 50);

        // Drop enable mid-frame
        wait_busy(40, n);
        @(negedge clk);
        enable = 1'b0;
        wait_valid(10, n);
        check("den_lat", n, 5);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (sample_valid || busy) pulses++;
        end
        check("den_quiet", pulses, 0);
        @(negedge clk);
        enable = 1'b1;
        wait_valid(40, n);
        check("reen_lat", n, 21);

        // Divider too short: overrun on second tick
        @(negedge clk);
        set_voices(100, 50, -20);
        filt_mask_b = 3'b001;
        volume_b    = 4'd15;
        enable_b    = 1'b1;
        rst_b       = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("ovr_pre", int'(overrun_b), 0);
        @(posedge clk);
        #1;
        check("ovr_set", int'(overrun_b), 1);
        @(posedge clk);
        #1;
        check("ovr_valid", int'(sample_valid_b), 1);
        check("ovr_filt", int'($signed(filt_out_b)), 93);
        repeat (20) @(posedge clk);
        #1;
        check("ovr_sticky", int'(overrun_b), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
